// File: rtl/date_pkg.sv
// Shared calendar constants and types for the date counters.
// Month numbering is 1-based; year is 0..99 meaning 2000..2099.
package date_pkg;

    typedef logic [7:0] date_t;

    localparam date_t JAN = 8'd1;
    localparam date_t FEB = 8'd2;
    localparam date_t MAR = 8'd3;
    localparam date_t APR = 8'd4;
    localparam date_t MAY = 8'd5;
    localparam date_t JUN = 8'd6;
    localparam date_t JUL = 8'd7;
    localparam date_t AUG = 8'd8;
    localparam date_t SEP = 8'd9;
    localparam date_t OCT = 8'd10;
    localparam date_t NOV = 8'd11;
    localparam date_t DEC = 8'd12;

    localparam date_t MAX_YEAR = 8'd99;
    localparam date_t MAX_DAY  = 8'd31;

    // Element [m] is the length of month m in a non-leap year.
    localparam logic [12:1][7:0] DAYS_NOLEAP = {
        8'd31, 8'd30, 8'd31, 8'd30,
        8'd31, 8'd31, 8'd30, 8'd31,
        8'd30, 8'd31, 8'd28, 8'd31
    };

endpackage

// File: rtl/month_len.sv
// Combinational month length lookup for (month, year).
// February becomes 29 on years divisible by 4 only with DATE_DOWN_LEAP_EN.
module month_len
    import date_pkg::*;
(
    input  logic [7:0] i_month,
    input  logic [7:0] i_year,
    output logic [7:0] o_days
);

    logic [3:0] w_idx;
    date_t      w_base;
    logic       w_unused_year;

    // Out-of-range months never reach here in use; map them safely.
    assign w_idx  = (i_month >= JAN && i_month <= DEC) ? i_month[3:0] : 4'd1;
    assign w_base = DAYS_NOLEAP[w_idx];

`ifdef DATE_DOWN_LEAP_EN
    logic w_leap;
    logic w_is_feb;

    assign w_leap        = (i_year[1:0] == 2'b00);
    assign w_is_feb      = (w_idx == FEB[3:0]);
    assign o_days        = (w_is_feb && w_leap) ? 8'd29 : w_base;
    assign w_unused_year = ^i_year[7:2];
`else
    assign o_days        = w_base;
    assign w_unused_year = ^i_year;
`endif

endmodule

// File: rtl/date_down_counter.sv
// Decrementing day/month/year counter with load clamping and borrow out.
// Leap-year February is enabled by defining DATE_DOWN_LEAP_EN.
module date_down_counter
    import date_pkg::*;
#(
    parameter int INIT_DAY   = 1,
    parameter int INIT_MONTH = 1,
    parameter int INIT_YEAR  = 0
) (
    input  logic       clk,
    input  logic       rst_h,
    input  logic       sub,
    input  logic       load,
    input  logic [7:0] load_day,
    input  logic [7:0] load_month,
    input  logic [7:0] load_year,
    output logic [7:0] day,
    output logic [7:0] month,
    output logic [7:0] year,
    output logic       borrow
);

    date_t r_day;
    date_t r_month;
    date_t r_year;

    date_t w_prev_month;
    date_t w_prev_len;
    date_t w_ld_month;
    date_t w_ld_year;
    date_t w_ld_len;
    date_t w_ld_day;
    date_t w_nxt_day;
    date_t w_nxt_month;
    date_t w_nxt_year;
    logic  w_at_floor;
    logic  w_at_epoch;

    assign w_prev_month = r_month - 8'd1;
    assign w_at_floor   = (r_day == 8'd1) && (r_month == JAN);
    assign w_at_epoch   = w_at_floor && (r_year == 8'd0);

    // Length of the month we fall back into, under the current year.
    month_len u_dec_len (
        .i_month (w_prev_month),
        .i_year  (r_year),
        .o_days  (w_prev_len)
    );

    assign w_ld_month = (load_month == 8'd0) ? JAN :
                        (load_month > DEC)   ? DEC : load_month;
    assign w_ld_year  = (load_year > MAX_YEAR) ? MAX_YEAR : load_year;

    month_len u_ld_len (
        .i_month (w_ld_month),
        .i_year  (w_ld_year),
        .o_days  (w_ld_len)
    );

    assign w_ld_day = (load_day == 8'd0)   ? 8'd1     :
                      (load_day > w_ld_len) ? w_ld_len : load_day;

    always_comb begin
        w_nxt_day   = r_day;
        w_nxt_month = r_month;
        w_nxt_year  = r_year;
        if (load) begin
            w_nxt_day   = w_ld_day;
            w_nxt_month = w_ld_month;
            w_nxt_year  = w_ld_year;
        end else if (sub) begin
            if (r_day > 8'd1) begin
                w_nxt_day = r_day - 8'd1;
            end else if (r_month > JAN) begin
                w_nxt_month = w_prev_month;
                w_nxt_day   = w_prev_len;
            end else begin
                w_nxt_month = DEC;
                w_nxt_day   = MAX_DAY;
                w_nxt_year  = (r_year == 8'd0) ? MAX_YEAR : r_year - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_h) begin
            r_day   <= date_t'(INIT_DAY);
            r_month <= date_t'(INIT_MONTH);
            r_year  <= date_t'(INIT_YEAR);
        end else begin
            r_day   <= w_nxt_day;
            r_month <= w_nxt_month;
            r_year  <= w_nxt_year;
        end
    end

    assign day    = r_day;
    assign month  = r_month;
    assign year   = r_year;
    assign borrow = sub && !load && !rst_h && w_at_epoch;

endmodule

// File: tb/tb_date_down_counter.sv
// Directed and random checks of date_down_counter against a calendar model.
// The model follows DATE_DOWN_LEAP_EN the same way the design build does.
module tb_date_down_counter;

    logic       clk;
    logic       rst_h;
    logic       sub;
    logic       load;
    logic [7:0] load_day;
    logic [7:0] load_month;
    logic [7:0] load_year;
    logic [7:0] day;
    logic [7:0] month;
    logic [7:0] year;
    logic       borrow;

    int nvec;
    int nerr;
    int md;
    int mm;
    int my;

    date_down_counter dut (
        .clk        (clk),
        .rst_h      (rst_h),
        .sub        (sub),
        .load       (load),
        .load_day   (load_day),
        .load_month (load_month),
        .load_year  (load_year),
        .day        (day),
        .month      (month),
        .year       (year),
        .borrow     (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dim(input int m, input int y);
        int t[13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        int r;
        r = t[m];
`ifdef DATE_DOWN_LEAP_EN
        if (m == 2 && (y % 4) == 0) r = 29;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit s, input bit l, input int ld,
                        input int lm, input int ly, input bit r);
        int eb;
        sub        = s;
        load       = l;
        load_day   = 8'(ld);
        load_month = 8'(lm);
        load_year  = 8'(ly);
        rst_h      = r;
        #1;
        eb = (s && !l && !r && md == 1 && mm == 1 && my == 0) ? 1 : 0;
        chk("borrow", {31'd0, borrow}, eb);
        @(posedge clk);
        if (r) begin
            md = 1; mm = 1; my = 0;
        end else if (l) begin
            mm = (lm == 0) ? 1 : (lm > 12 ? 12 : lm);
            my = (ly > 99) ? 99 : ly;
            md = (ld == 0) ? 1 : ld;
            if (md > dim(mm, my)) md = dim(mm, my);
        end else if (s) begin
            if (md > 1) md--;
            else if (mm > 1) begin
                mm--;
                md = dim(mm, my);
            end else begin
                mm = 12;
                md = 31;
                my = (my + 99) % 100;
            end
        end
        #1;
        chk("day", {24'd0, day}, md);
        chk("month", {24'd0, month}, mm);
        chk("year", {24'd0, year}, my);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        md = 1; mm = 1; my = 0;
        sub = 0; load = 0; rst_h = 1;
        load_day = 0; load_month = 0; load_year = 0;
        @(posedge clk);
        #1;

        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        step(0, 1, 1, 3, 24, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 3, 23, 0);
        step(1, 0, 0, 0, 0, 0);

        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 31; i++) step(1, 0, 0, 0, 0, 0);

        step(0, 1, 31, 4, 21, 0);
        step(0, 1, 0, 13, 150, 0);
        step(0, 1, 30, 2, 20, 0);

        step(0, 0, 0, 0, 0, 1);
        step(1, 1, 15, 6, 10, 0);

        step(0, 1, 5, 5, 5, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            bit r;
            bit l;
            bit s;
            int ld;
            int lm;
            int ly;
            r  = ($urandom % 60) == 0;
            l  = ($urandom % 10) == 0;
            s  = ($urandom % 4) != 0;
            ld = $urandom_range(0, 40);
            lm = $urandom_range(0, 15);
            ly = ($urandom % 3 == 0) ? $urandom_range(0, 255)
                                     : $urandom_range(0, 3);
            if ($urandom % 4 == 0) begin
                ld = 1;
                lm = $urandom_range(1, 3);
            end
            step(s, l, ld, lm, ly, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/date_down_counter.md
# date_down_counter

Decrementing calendar counter holding day, month and two-digit year as binary values. Each `sub` pulse moves the date back one day and applies month-length and leap-year rules on the wrap from day 1. It is the count-down counterpart of the clock's day/month/year up-counter chain, and is used for countdown and back-setting of the date. A combinational `borrow` goes out on the wrap below 01/01/00.

## Interface
Parameters:
- `INIT_DAY`, default 1: reset day.
- `INIT_MONTH`, default 1: reset month.
- `INIT_YEAR`, default 0: reset year (00 = 2000).

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_h` in 1: reset, synchronous and active-high.
- `sub` in 1: decrement-one-day request; sampled each cycle.
- `load` in 1: load request; takes priority over `sub`.
- `load_day` in 8: day to load.
- `load_month` in 8: month to load.
- `load_year` in 8: year to load.
- `day` out 8: current day, 1..31.
- `month` out 8: current month, 1..12.
- `year` out 8: current year, 0..99.
- `borrow` out 1: combinational; high when `sub`=1, `load`=0, `rst_h`=0 and state is 01/01/00.

## Operation
- Registered state: `day`, `month`, `year`. Reset values are `INIT_DAY`/`INIT_MONTH`/`INIT_YEAR`.
- Priority each cycle: `rst_h` > `load` > `sub` > hold.
- Days in month: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; February 29 if leap, else 28.
- Leap rule: `year % 4 == 0`. Year 0 counts as leap (2000).
- Decrement, when `sub` is the winning request:
  - If `day` > 1: `day` = `day` − 1.
  - Else if `month` > 1: `month` = `month` − 1, and `day` = days in the new month, evaluated with the current `year`.
  - Else: `month` = 12, `day` = 31, and `year` = `year` − 1. Year 0 wraps to 99, and `borrow` is high in this cycle.
- Load:
  - `load_month` is clamped to 1..12: 0 → 1, >12 → 12.
  - `load_year` above 99 is clamped to 99.
  - `load_day` 0 → 1. A `load_day` above the length of the clamped month (under the clamped year) is clamped to that length.
- Out-of-range state cannot arise. Every path into the registers is clamped or wrap-defined.
- `borrow` is low whenever `load` or `rst_h` is high.

## Timing
- Latency: a new date is visible on the outputs the cycle after the `sub` or `load` edge.
- `sub` held high decrements once per cycle. There is no edge detection; upstream delivers single-cycle pulses.
- `borrow` is combinational from the registered state and `sub`, in the same cycle as the wrapping `sub`. It is intended for the next counter stage's decrement input.
- `rst_h` asserted mid-operation: registers take reset values at the next edge and `borrow` drops immediately. A `sub` or `load` present in that cycle is discarded.
- `load` and `sub` in the same cycle: the load wins and the `sub` is lost, not queued.

## Configuration
- `DATE_DOWN_LEAP_EN` defined: February length follows the leap rule above.
- Macro undefined: February is always 28 days, and leap logic is not synthesized. A load of 29/02 clamps to 28/02.

## Structure
- Shared package `date_pkg`:
  - Month constants `JAN`..`DEC`.
  - `MAX_YEAR` = 99.
  - Constant `DAYS_NOLEAP` per month.
  - Typedef for the 8-bit date field.
- Sub-module `month_len`: combinational, (month, year) → days in month, leap-gated by the macro. It is instantiated twice, once for the decrement path (new month) and once for the load clamp.

## Test plan
- Reset → 01/01/00 with `borrow`=0; cycle `rst_h` with `sub` high → state stays 01/01/00.
- Load 01/03/24, one `sub` → 29/02/24. Load 01/03/23, one `sub` → 28/02/23. With the macro undefined, 01/03/24 → 28/02/24.
- State 01/01/00, `sub`=1 → `borrow`=1 that cycle, next state 31/12/99. 31 more `sub` pulses → 30/11/99 with `borrow` never high.
- Load 31/04/21 → 30/04/21. Load 00/13/150 → 01/12/99. Load 30/02/20 → 29/02/20.
- `load`=1 and `sub`=1 together with load 15/06/10 → 15/06/10 and `borrow`=0, even when the prior state was 01/01/00.
- Stepping from 05/05/05, assert `rst_h` on the 3rd `sub` → state 01/01/00 the next cycle, and subsequent `sub` pulses resume from there.
